// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and constants for the stream round-robin arbiter.
// Holds the FSM encoding, default beat width and packet-counter width.
package stream_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 128;
    localparam int PKT_COUNT_WIDTH    = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // (base + off) mod n, used for rotating source indices
    function automatic int unsigned wrap_add(
        input int unsigned base,
        input int unsigned off,
        input int unsigned n
    );
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of per-source stream inputs and the fifo write port.
// master: arbiter view; slave: environment (sources + fifo) view.
interface stream_rr_arbiter_if
    import stream_arb_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ID_WIDTH   = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1
);

    logic [N_SRC-1:0]            s_tvalid;
    logic [N_SRC-1:0]            s_tready;
    logic [N_SRC*DATA_WIDTH-1:0] s_tdata;
    logic [N_SRC-1:0]            s_tlast;

    logic                        fifo_write_tvalid;
    logic                        fifo_write_tready;
    logic [DATA_WIDTH-1:0]       fifo_wdata;
    logic [ID_WIDTH-1:0]         fifo_wid;
    logic                        fifo_wlast;

    modport master (
        input  s_tvalid,
        output s_tready,
        input  s_tdata,
        input  s_tlast,
        output fifo_write_tvalid,
        input  fifo_write_tready,
        output fifo_wdata,
        output fifo_wid,
        output fifo_wlast
    );

    modport slave (
        output s_tvalid,
        input  s_tready,
        output s_tdata,
        output s_tlast,
        input  fifo_write_tvalid,
        output fifo_write_tready,
        input  fifo_wdata,
        input  fifo_wid,
        input  fifo_wlast
    );

endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N_SRC, plus an any-request flag.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int N_SRC    = 2,
    parameter int ID_WIDTH = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0]    req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                any_req
);

    logic [ID_WIDTH-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        cand_s    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand_s    = ID_WIDTH'(wrap_add(32'(ptr), k, N_SRC));
            grant_idx = req[cand_s] ? cand_s : grant_idx;
            any_req   = req[cand_s] ? 1'b1 : any_req;
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter merging N_SRC streams into one fifo
// write port through a single skid-free output register.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ID_WIDTH   = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    stream_rr_arbiter_if.master        bus,
    output logic [PKT_COUNT_WIDTH-1:0] pkt_count
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_BUSY = BUSY;

    logic [0:0]                 state_q, state_d;
    logic [ID_WIDTH-1:0]        grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
    logic                       out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]        out_id_q, out_id_d;
    logic                       out_last_q, out_last_d;
    logic [PKT_COUNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    logic [ID_WIDTH-1:0]        pick_id_s;
    logic                       any_req_s;
    logic                       sel_valid_s;
    logic                       sel_last_s;
    logic [DATA_WIDTH-1:0]      sel_data_s;
    logic                       out_free_s;
    logic                       out_hs_s;
    logic                       accept_s;
    logic [N_SRC-1:0]           ready_s;

    rr_pick #(
        .N_SRC    (N_SRC),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req       (bus.s_tvalid),
        .ptr       (rr_ptr_q),
        .grant_idx (pick_id_s),
        .any_req   (any_req_s)
    );

    // Granted-source mux and handshake qualifiers; the output register
    // is free when empty or draining this cycle
    always_comb begin
        sel_valid_s = bus.s_tvalid[grant_id_q];
        sel_last_s  = bus.s_tlast[grant_id_q];
        sel_data_s  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            sel_data_s = (grant_id_q == ID_WIDTH'(i)) ?
                         bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
        end
        out_free_s = !out_valid_q || bus.fifo_write_tready;
        out_hs_s   = out_valid_q && bus.fifo_write_tready;
        accept_s   = (state_q == ST_BUSY) && out_free_s && sel_valid_s;
        ready_s    = '0;
        if (state_q == ST_BUSY) begin
            ready_s[grant_id_q] = out_free_s;
        end else begin
            ready_s = '0;
        end
    end

    // Next-state for arbitration FSM, output register and packet counter
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_last_d  = out_last_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_id_d = pick_id_s;
                    state_d    = ST_BUSY;
                end else begin
                    grant_id_d = grant_id_q;
                    state_d    = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Grant is held until the last beat is taken, then the
                // pointer moves past the source just served
                if (accept_s && sel_last_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ID_WIDTH'(wrap_add(32'(grant_id_q), 32'd1, N_SRC));
                end else begin
                    state_d  = ST_BUSY;
                    rr_ptr_d = rr_ptr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_id_d    = grant_id_q;
            out_last_d  = sel_last_s;
        end else if (out_hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (out_hs_s && out_last_q) begin
            pkt_count_d = pkt_count_q + PKT_COUNT_WIDTH'(1);
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign bus.s_tready          = ready_s;
    assign bus.fifo_write_tvalid = out_valid_q;
    assign bus.fifo_wdata        = out_data_q;
    assign bus.fifo_wid          = out_id_q;
    assign bus.fifo_wlast        = out_last_q;
    assign pkt_count             = pkt_count_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: table of arbitration scenarios,
// stall / reset corner cases, and a long random run with a per-source scoreboard.
module tb_stream_rr_arbiter;

    localparam int NS = 2;
    localparam int DW = 128;
    localparam int IW = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int         npk0;
        int         npk1;
        int         len;
        logic [7:0] ord;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] pkt_count;

    stream_rr_arbiter_if #(.N_SRC(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    stream_rr_arbiter #(.N_SRC(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_cmp = 0;
    int        n_err = 0;
    beat_t     exp_q [2][$];
    int        plan  [2][$];
    int        pkt_ids[$];
    int        out_beats = 0;
    bit        sb_en = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: hold-while-stalled, no interleaving, scoreboard pop
    initial begin : monitor
        bit            prev_stall;
        bit            mid_pkt;
        int            cur_id;
        logic [DW-1:0] p_data;
        logic [IW-1:0] p_id;
        logic          p_last;
        beat_t         e;
        prev_stall = 1'b0;
        mid_pkt    = 1'b0;
        cur_id     = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                mid_pkt    = 1'b0;
                out_beats  = 0;
                pkt_ids.delete();
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", bus.fifo_write_tvalid, 1);
                    chk("hold_data", bus.fifo_wdata, p_data);
                    chk("hold_id", bus.fifo_wid, p_id);
                    chk("hold_last", bus.fifo_wlast, p_last);
                end
                if (bus.fifo_write_tvalid && !bus.fifo_write_tready)
                    chk("stall_tready", bus.s_tready, 0);
                if (bus.fifo_write_tvalid && bus.fifo_write_tready && sb_en) begin
                    out_beats++;
                    if (mid_pkt) chk("interleave", bus.fifo_wid, cur_id);
                    if (exp_q[bus.fifo_wid].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat", bus.fifo_wid, bus.fifo_wdata);
                    end else begin
                        e = exp_q[bus.fifo_wid].pop_front();
                        chk("sb_data", bus.fifo_wdata, e.data);
                        chk("sb_last", bus.fifo_wlast, e.last);
                    end
                    if (bus.fifo_wlast) begin
                        mid_pkt = 1'b0;
                        pkt_ids.push_back(int'(bus.fifo_wid));
                    end else begin
                        mid_pkt = 1'b1;
                        cur_id  = int'(bus.fifo_wid);
                    end
                end
                prev_stall = bus.fifo_write_tvalid && !bus.fifo_write_tready;
                p_data     = bus.fifo_wdata;
                p_id       = bus.fifo_wid;
                p_last     = bus.fifo_wlast;
            end
        end
    end

    task automatic do_reset();
        reset                 = 1'b1;
        bus.s_tvalid          = '0;
        bus.s_tlast           = '0;
        bus.s_tdata           = '0;
        bus.fifo_write_tready = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        plan[0].delete();
        plan[1].delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus.fifo_write_tvalid, 0);
        chk("rst_wdata", bus.fifo_wdata, 0);
        chk("rst_wid", bus.fifo_wid, 0);
        chk("rst_wlast", bus.fifo_wlast, 0);
        chk("rst_tready", bus.s_tready, 0);
        chk("rst_pkt_count", pkt_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", bus.fifo_write_tvalid, 0);
        @(posedge clk);
        #1;
    endtask

    // Drives the planned packets on both sources with given valid/ready
    // percentages until everything has drained through the fifo port
    task automatic run_traffic(input int p_valid, input int p_ready, input int stall_after, input int budget);
        int left[2];
        bit hs[2];
        int cyc;
        int stall_cnt;
        bit stalled;
        bit busy;
        left      = '{0, 0};
        cyc       = 0;
        stall_cnt = 0;
        stalled   = 1'b0;
        busy      = 1'b1;
        while (busy && cyc < budget) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                hs[s] = bus.s_tvalid[s] && bus.s_tready[s];
                if (hs[s]) begin
                    exp_q[s].push_back({bus.s_tdata[s*DW +: DW], bus.s_tlast[s]});
                    left[s]--;
                end
            end
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (!(bus.s_tvalid[s] && !hs[s])) begin
                    if (left[s] == 0 && plan[s].size() != 0) left[s] = plan[s].pop_front();
                    if (left[s] > 0 && $urandom_range(99) < p_valid) begin
                        bus.s_tvalid[s]          = 1'b1;
                        bus.s_tdata[s*DW +: DW]  = {$urandom, $urandom, $urandom, $urandom};
                        bus.s_tlast[s]           = (left[s] == 1);
                    end else begin
                        bus.s_tvalid[s] = 1'b0;
                    end
                end
            end
            if (stall_cnt > 0) begin
                bus.fifo_write_tready = 1'b0;
                stall_cnt--;
            end else if (!stalled && stall_after >= 0 && out_beats >= stall_after) begin
                stalled               = 1'b1;
                stall_cnt             = 4;
                bus.fifo_write_tready = 1'b0;
            end else begin
                bus.fifo_write_tready = ($urandom_range(99) < p_ready);
            end
            busy = (plan[0].size() != 0) || (plan[1].size() != 0) || (left[0] != 0) || (left[1] != 0)
                || (bus.s_tvalid != '0) || (exp_q[0].size() != 0) || (exp_q[1].size() != 0)
                || bus.fifo_write_tvalid;
            cyc++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got %0d cycles without draining, expected drain within %0d", cyc, budget);
            bus.s_tvalid = '0;
        end
    endtask

    initial begin : stim
        vec_t vec[6];
        int   n;
        int   acc;
        int   g;
        bit   hs0;
        int   npk;
        int   total;
        int   len;
        int   src;

        // {packets on src0, packets on src1, beats per packet, packet order (bit k = wid of packet k)}
        vec[0] = '{1, 0, 4, 8'b0000_0000};
        vec[1] = '{3, 3, 2, 8'b0010_1010};
        vec[2] = '{0, 2, 1, 8'b0000_0011};
        vec[3] = '{2, 1, 3, 8'b0000_0010};
        vec[4] = '{1, 3, 1, 8'b0000_1110};
        vec[5] = '{4, 0, 1, 8'b0000_0000};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int k = 0; k < vec[v].npk0; k++) plan[0].push_back(vec[v].len);
            for (int k = 0; k < vec[v].npk1; k++) plan[1].push_back(vec[v].len);
            n = vec[v].npk0 + vec[v].npk1;
            run_traffic(100, 100, -1, 500);
            @(negedge clk);
            chk("order_len", pkt_ids.size(), n);
            for (int k = 0; k < n && k < pkt_ids.size(); k++)
                chk("order_id", pkt_ids[k], vec[v].ord[k]);
            chk("vec_pkt_count", pkt_count, n);
            chk("vec_beats", out_beats, n * vec[v].len);
        end

        // Fifo stalls for 5 cycles in the middle of a 4-beat packet
        do_reset();
        plan[0].push_back(4);
        run_traffic(100, 100, 2, 500);
        @(negedge clk);
        chk("stall_beats", out_beats, 4);
        chk("stall_pkt_count", pkt_count, 1);

        // Reset after two beats of a 4-beat packet, then a fresh packet on source 1
        do_reset();
        sb_en                 = 1'b0;
        bus.fifo_write_tready = 1'b1;
        bus.s_tvalid[0]       = 1'b1;
        bus.s_tdata[0 +: DW]  = {$urandom, $urandom, $urandom, $urandom};
        bus.s_tlast[0]        = 1'b0;
        acc = 0;
        g   = 0;
        while (acc < 2 && g < 50) begin
            @(negedge clk);
            hs0 = bus.s_tvalid[0] && bus.s_tready[0];
            @(posedge clk);
            #1;
            g++;
            if (hs0) begin
                acc++;
                bus.s_tdata[0 +: DW] = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        chk("pre_reset_accepts", acc, 2);
        do_reset();
        sb_en = 1'b1;
        plan[1].push_back(1);
        run_traffic(100, 100, -1, 200);
        @(negedge clk);
        chk("rst_mid_beats", out_beats, 1);
        chk("rst_mid_pkt_count", pkt_count, 1);
        chk("rst_mid_npk", pkt_ids.size(), 1);
        if (pkt_ids.size() != 0) chk("rst_mid_wid", pkt_ids[0], 1);

        // Long random run with valid drops on both sources and random fifo backpressure
        do_reset();
        npk   = 0;
        total = 0;
        while (total < 11000) begin
            src = int'($urandom_range(1));
            len = int'($urandom_range(8, 1));
            plan[src].push_back(len);
            total += len;
            npk++;
        end
        run_traffic(75, 75, -1, 70000);
        @(negedge clk);
        chk("rand_beats", out_beats, total);
        chk("rand_pkt_count", pkt_count, 16'(npk));
        chk("rand_npk", pkt_ids.size(), npk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter N_SRC, default 2, number of requesting streams (2..8).
REQ-002 Parameter DATA_WIDTH, default 128, beat width matching the fifo write port.
REQ-003 Parameter ID_WIDTH, default max(1, clog2(N_SRC)), width of the source tag.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 s_tvalid  in  N_SRC  per-source beat valid.
REQ-007 s_tready  out  N_SRC  per-source beat ready.
REQ-008 s_tdata  in  N_SRC*DATA_WIDTH  per-source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 s_tlast  in  N_SRC  per-source last beat of packet.
REQ-010 fifo_write_tvalid  out  1  beat valid toward fifo write port.
REQ-011 fifo_write_tready  in  1  fifo write port ready.
REQ-012 fifo_wdata  out  DATA_WIDTH  beat data toward fifo.
REQ-013 fifo_wid  out  ID_WIDTH  source index of current output beat.
REQ-014 fifo_wlast  out  1  last beat of packet for current output beat.
REQ-015 pkt_count  out  16  completed packets forwarded, wraps 0xFFFF->0.

Function
REQ-016 FSM states IDLE and BUSY; grant register grant_id; round-robin pointer rr_ptr.
REQ-017 IDLE: all s_tready low; if any s_tvalid high, grant_id <= first index with s_tvalid high searching rr_ptr, rr_ptr+1, ... modulo N_SRC; next state BUSY.
REQ-018 IDLE with no s_tvalid: stay IDLE, grant_id and rr_ptr unchanged.
REQ-019 BUSY: s_tready[grant_id] = !fifo_write_tvalid || fifo_write_tready; all other s_tready bits low.
REQ-020 Accepted beat (s_tvalid & s_tready on granted source) loads output register: fifo_wdata, fifo_wid = grant_id, fifo_wlast = s_tlast; fifo_write_tvalid high next cycle (latency 1 cycle).
REQ-021 Output register holds data/id/last stable while fifo_write_tvalid high and fifo_write_tready low.
REQ-022 Output handshake with no new accept in same cycle: fifo_write_tvalid low next cycle.
REQ-023 Output handshake and new accept in same cycle: register reloads, fifo_write_tvalid stays high; full throughput of one beat per cycle.
REQ-024 Accepted beat with s_tlast high: next state IDLE, rr_ptr <= (grant_id+1) mod N_SRC; grant held for entire packet otherwise (no interleaving).
REQ-025 pkt_count increments by 1 when an output beat with fifo_wlast high handshakes at fifo side.
REQ-026 Requester dropping s_tvalid mid-packet: grant retained, arbiter waits indefinitely.
REQ-027 Minimum packet gap: one IDLE cycle between packets on the input side; output may still stream the final beat during that cycle.

Reset
REQ-028 On reset: state IDLE, rr_ptr 0, grant_id 0, fifo_write_tvalid 0, fifo_wdata 0, fifo_wid 0, fifo_wlast 0, s_tready all 0, pkt_count 0.
REQ-029 Reset mid-packet discards the partial packet and the output register content; no beat is emitted in the cycle following reset.

Structure
REQ-030 Package stream_arb_pkg holds the state enum (IDLE, BUSY), the default DATA_WIDTH, and the pkt_count width constant.
REQ-031 Sub-module rr_pick: combinational N_SRC-way picker taking request vector and rr_ptr, returning the granted index and an any-request flag.

Verification
REQ-032 Single source 0, 4-beat packet, fifo_write_tready constant 1 -> 4 output beats in order with fifo_wid 0, fifo_wlast on beat 4 only, pkt_count 1.
REQ-033 Both sources continuously valid, 2-beat packets, 6 packets -> fifo_wid sequence 0,1,0,1,0,1 and no interleaved beats.
REQ-034 fifo_write_tready held low for 5 cycles mid-packet -> fifo_wdata and fifo_wid stable, s_tready low, no beat lost or duplicated.
REQ-035 Reset asserted after beat 2 of a 4-beat packet, then fresh 1-beat packet on source 1 -> only the new beat emitted, fifo_wid 1, pkt_count 1.
REQ-036 Random valid/ready on both sources and fifo side, 11000 beats, 128-bit random data -> per-source scoreboard matches, pkt_count equals packets sent mod 65536.
